// File: rtl/iommu_reg_ctrl_pkg.sv
// Shared types and helpers for the IOMMU register-bus front end and the
// HW-side register map.
package iommu_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned REG_BYTES = 4;
  localparam int unsigned REG_WIDTH = 8 * REG_BYTES;
  localparam int unsigned OFFS_WIDTH = $clog2(REG_BYTES);

  // Bytes whose strobe is clear keep the current field contents.
  function automatic logic [REG_WIDTH-1:0] merge_strb(
    input logic [REG_WIDTH-1:0] wdata,
    input logic [REG_BYTES-1:0] wstrb,
    input logic [REG_WIDTH-1:0] qs
  );
    logic [REG_WIDTH-1:0] res;
    res = '0;
    for (int b = 0; b < REG_BYTES; b++) begin
      res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : qs[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iommu_reg_decode.sv
// Combinational address decoder: byte address -> one-hot slot select, slot
// index and decode error. Shared with the HW-side register map.
module iommu_reg_decode
  import iommu_reg_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned N_FIELDS   = 16,
  parameter int unsigned IDX_WIDTH  = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [N_FIELDS-1:0]   sel_o,
  output logic [IDX_WIDTH-1:0]  index_o,
  output logic                  err_o
);

  localparam int unsigned WORD_WIDTH = ADDR_WIDTH - OFFS_WIDTH;

  logic [WORD_WIDTH-1:0] word;
  logic                  misaligned;
  logic                  out_of_range;

  assign word         = addr_i[ADDR_WIDTH-1:OFFS_WIDTH];
  assign misaligned   = |addr_i[OFFS_WIDTH-1:0];
  assign out_of_range = (32'(word) >= 32'(N_FIELDS));
  assign err_o        = misaligned | out_of_range;
  assign index_o      = word[IDX_WIDTH-1:0];

  // Compare the full word so out-of-range addresses never alias onto a slot.
  always_comb begin
    sel_o = '0;
    for (int k = 0; k < N_FIELDS; k++) begin
      if (!err_o && (32'(word) == 32'(k))) begin
        sel_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iommu_reg_ctrl.sv
// SW register-bus front end: one outstanding valid/ready request, decoded to a
// single field slot, with a one-cycle write/read pulse and a registered response.
module iommu_reg_ctrl
  import iommu_reg_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH    = 12,
  parameter int unsigned          DATA_WIDTH    = 32,
  parameter int unsigned          N_FIELDS      = 16,
  parameter logic [N_FIELDS-1:0]  RD_PULSE_MASK = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,

  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [ADDR_WIDTH-1:0]          req_addr_i,
  input  logic                           req_write_i,
  input  logic [DATA_WIDTH-1:0]          req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        req_wstrb_i,

  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                           rsp_error_o,

  output logic [N_FIELDS-1:0]            field_we_o,
  output logic [N_FIELDS-1:0]            field_re_o,
  output logic [DATA_WIDTH-1:0]          field_wd_o,
  input  logic [N_FIELDS*DATA_WIDTH-1:0] field_qs_i
);

  localparam int unsigned IDX_WIDTH = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    error_q, error_d;

  logic                    req_hs;
  logic                    rsp_hs;

  logic [N_FIELDS-1:0]     dec_sel;
  logic [IDX_WIDTH-1:0]    dec_index;
  logic                    dec_err;

  logic [DATA_WIDTH-1:0]   qs_slot [N_FIELDS];
  logic [DATA_WIDTH-1:0]   qs_sel;
  logic                    do_write;
  logic                    do_read;

  iommu_reg_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_FIELDS   (N_FIELDS),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_decode (
    .addr_i  (addr_q),
    .sel_o   (dec_sel),
    .index_o (dec_index),
    .err_o   (dec_err)
  );

  for (genvar k = 0; k < N_FIELDS; k++) begin : g_qs_slot
    assign qs_slot[k] = field_qs_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign qs_sel   = qs_slot[dec_index];
  assign req_hs   = (state_q == IDLE) && req_valid_i;
  assign rsp_hs   = (state_q == RESP) && rsp_ready_i;
  assign do_write = (state_q == ACCESS) && write_q && !dec_err;
  assign do_read  = (state_q == ACCESS) && !write_q && !dec_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    field_we_o  = '0;
    field_re_o  = '0;
    field_wd_o  = '0;
    if (do_write) begin
      field_wd_o = merge_strb(wdata_q, wstrb_q, qs_sel);
      if (|wstrb_q) begin
        field_we_o = dec_sel;
      end
    end
    if (do_read) begin
      field_re_o = dec_sel & RD_PULSE_MASK;
    end
  end

  // Read data is the pre-update qs, captured while the pulse is in flight.
  always_comb begin
    rdata_d = rdata_q;
    error_d = error_q;
    if (state_q == ACCESS) begin
      rdata_d = do_read ? qs_sel : '0;
      error_d = dec_err;
    end else if (rsp_hs) begin
      rdata_d = '0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (req_hs) begin
        addr_q  <= req_addr_i;
        write_q <= req_write_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
      end
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;

endmodule

// File: tb/tb_iommu_reg_ctrl.sv
// Self-checking bench for iommu_reg_ctrl: table-driven transactions with a
// response scoreboard, plus back-pressure and mid-transaction reset sequences.
module tb_iommu_reg_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NF = 16;
  localparam logic [NF-1:0] MASK = 16'h0088;

  logic            clk;
  logic            rstN;
  logic            reqValid;
  logic            reqReady;
  logic [AW-1:0]   reqAddr;
  logic            reqWrite;
  logic [DW-1:0]   reqWdata;
  logic [DW/8-1:0] reqWstrb;
  logic            rspValid;
  logic            rspReady;
  logic [DW-1:0]   rspRdata;
  logic            rspError;
  logic [NF-1:0]   fieldWe;
  logic [NF-1:0]   fieldRe;
  logic [DW-1:0]   fieldWd;
  logic [NF*DW-1:0] fieldQs;
  logic [DW-1:0]   qsModel [NF];

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [NF-1:0] expWe;
    logic [NF-1:0] expRe;
    logic [31:0]   expWd;
    logic [31:0]   expRdata;
    logic          expErr;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs [12];
  rsp_t expQ [$];
  int   nChecks = 0;
  int   nFail   = 0;

  iommu_reg_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .N_FIELDS      (NF),
    .RD_PULSE_MASK (MASK)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .req_valid_i (reqValid),
    .req_ready_o (reqReady),
    .req_addr_i  (reqAddr),
    .req_write_i (reqWrite),
    .req_wdata_i (reqWdata),
    .req_wstrb_i (reqWstrb),
    .rsp_valid_o (rspValid),
    .rsp_ready_i (rspReady),
    .rsp_rdata_o (rspRdata),
    .rsp_error_o (rspError),
    .field_we_o  (fieldWe),
    .field_re_o  (fieldRe),
    .field_wd_o  (fieldWd),
    .field_qs_i  (fieldQs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fieldQs = '0;
    for (int k = 0; k < NF; k++) fieldQs[k*DW +: DW] = qsModel[k];
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveReq(input logic [AW-1:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    reqValid = 1'b1;
    reqAddr  = a;
    reqWrite = w;
    reqWdata = d;
    reqWstrb = s;
  endtask

  // Waits (bounded) until the request is accepted; returns at the ACCESS negedge.
  task automatic waitAccept(output bit ok);
    int waitCnt;
    waitCnt = 0;
    while (reqReady !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    ok = (reqReady === 1'b1);
    if (!ok) checkOutput("req_ready timeout", 32'(reqReady), 32'd1);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input int holdCycles);
    bit   ok;
    rsp_t e;
    @(negedge clk);
    driveReq(v.addr, v.write, v.wdata, v.wstrb);
    expQ.push_back('{rdata: v.expRdata, err: v.expErr});
    waitAccept(ok);
    reqValid = 1'b0;
    if (!ok) begin
      void'(expQ.pop_back());
      return;
    end
    checkOutput("field_we in ACCESS", 32'(fieldWe), 32'(v.expWe));
    checkOutput("field_re in ACCESS", 32'(fieldRe), 32'(v.expRe));
    if (v.expWe != '0) checkOutput("field_wd merge", fieldWd, v.expWd);
    @(negedge clk);
    checkOutput("rsp_valid latency", 32'(rspValid), 32'd1);
    checkOutput("no pulse in RESP", 32'(fieldWe | fieldRe), 32'd0);
    checkOutput("field_wd zero in RESP", fieldWd, 32'd0);
    e = expQ.pop_front();
    checkOutput("rsp_rdata", rspRdata, e.rdata);
    checkOutput("rsp_error", 32'(rspError), 32'(e.err));
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("rsp held valid", 32'(rspValid), 32'd1);
      checkOutput("rsp held rdata", rspRdata, e.rdata);
      checkOutput("req_ready low in RESP", 32'(reqReady), 32'd0);
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("rsp_valid after handshake", 32'(rspValid), 32'd0);
    checkOutput("req_ready after handshake", 32'(reqReady), 32'd1);
  endtask

  initial begin
    bit   ok;
    rsp_t e;

    for (int k = 0; k < NF; k++) qsModel[k] = 32'h1000_0000 + 32'(k);
    qsModel[2] = 32'h1122_3344;
    qsModel[3] = 32'h0000_0F0F;
    qsModel[7] = 32'hCAFE_F00D;

    vecs[0]  = '{addr: 12'h004, write: 1'b1, wdata: 32'hDEADBEEF, wstrb: 4'hF, expWe: 16'h0002, expRe: 16'h0000, expWd: 32'hDEADBEEF, expRdata: 32'h0, expErr: 1'b0};
    vecs[1]  = '{addr: 12'h008, write: 1'b1, wdata: 32'hAABBCCDD, wstrb: 4'h5, expWe: 16'h0004, expRe: 16'h0000, expWd: 32'h11BB33DD, expRdata: 32'h0, expErr: 1'b0};
    vecs[2]  = '{addr: 12'h00C, write: 1'b0, wdata: 32'h0,        wstrb: 4'h0, expWe: 16'h0000, expRe: 16'h0008, expWd: 32'h0,        expRdata: 32'h00000F0F, expErr: 1'b0};
    vecs[3]  = '{addr: 12'h006, write: 1'b0, wdata: 32'h0,        wstrb: 4'h0, expWe: 16'h0000, expRe: 16'h0000, expWd: 32'h0,        expRdata: 32'h0, expErr: 1'b1};
    vecs[4]  = '{addr: 12'h040, write: 1'b0, wdata: 32'h0,        wstrb: 4'h0, expWe: 16'h0000, expRe: 16'h0000, expWd: 32'h0,        expRdata: 32'h0, expErr: 1'b1};
    vecs[5]  = '{addr: 12'h01C, write: 1'b0, wdata: 32'h0,        wstrb: 4'h0, expWe: 16'h0000, expRe: 16'h0080, expWd: 32'h0,        expRdata: 32'hCAFEF00D, expErr: 1'b0};
    vecs[6]  = '{addr: 12'h010, write: 1'b0, wdata: 32'h0,        wstrb: 4'h0, expWe: 16'h0000, expRe: 16'h0000, expWd: 32'h0,        expRdata: 32'h10000004, expErr: 1'b0};
    vecs[7]  = '{addr: 12'h03C, write: 1'b1, wdata: 32'h12345678, wstrb: 4'h0, expWe: 16'h0000, expRe: 16'h0000, expWd: 32'h0,        expRdata: 32'h0, expErr: 1'b0};
    vecs[8]  = '{addr: 12'h03E, write: 1'b1, wdata: 32'h12345678, wstrb: 4'hF, expWe: 16'h0000, expRe: 16'h0000, expWd: 32'h0,        expRdata: 32'h0, expErr: 1'b1};
    vecs[9]  = '{addr: 12'h03C, write: 1'b1, wdata: 32'h12345678, wstrb: 4'hA, expWe: 16'h8000, expRe: 16'h0000, expWd: 32'h1200560F, expRdata: 32'h0, expErr: 1'b0};
    vecs[10] = '{addr: 12'hFFC, write: 1'b0, wdata: 32'h0,        wstrb: 4'h0, expWe: 16'h0000, expRe: 16'h0000, expWd: 32'h0,        expRdata: 32'h0, expErr: 1'b1};
    vecs[11] = '{addr: 12'h000, write: 1'b0, wdata: 32'h0,        wstrb: 4'h0, expWe: 16'h0000, expRe: 16'h0000, expWd: 32'h0,        expRdata: 32'h10000000, expErr: 1'b0};

    rstN     = 1'b0;
    reqValid = 1'b0;
    reqAddr  = '0;
    reqWrite = 1'b0;
    reqWdata = '0;
    reqWstrb = '0;
    rspReady = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", 32'(reqReady), 32'd1);
    checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset pulses", 32'(fieldWe | fieldRe), 32'd0);
    checkOutput("reset field_wd", fieldWd, 32'd0);
    checkOutput("reset rsp_rdata", rspRdata, 32'd0);
    checkOutput("reset rsp_error", 32'(rspError), 32'd0);
    rstN = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], (i == 3) ? 2 : 0);

    $display("[TB] back-pressure sequence");
    @(negedge clk);
    driveReq(12'h00C, 1'b0, 32'h0, 4'h0);
    expQ.push_back('{rdata: 32'h00000F0F, err: 1'b0});
    waitAccept(ok);
    driveReq(12'h01C, 1'b0, 32'h0, 4'h0);
    expQ.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
    checkOutput("bp first re pulse", 32'(fieldRe), 32'h0008);
    @(negedge clk);
    e = expQ.pop_front();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp rsp_valid held", 32'(rspValid), 32'd1);
      checkOutput("bp rdata stable", rspRdata, e.rdata);
      checkOutput("bp error stable", 32'(rspError), 32'(e.err));
      checkOutput("bp req_ready low", 32'(reqReady), 32'd0);
      checkOutput("bp no pulse", 32'(fieldWe | fieldRe), 32'd0);
      @(negedge clk);
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("bp req_ready after handshake", 32'(reqReady), 32'd1);
    checkOutput("bp rsp_valid after handshake", 32'(rspValid), 32'd0);
    checkOutput("bp not yet accepted", 32'(fieldRe), 32'd0);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("bp second re pulse", 32'(fieldRe), 32'h0080);
    @(negedge clk);
    e = expQ.pop_front();
    checkOutput("bp second rsp_valid", 32'(rspValid), 32'd1);
    checkOutput("bp second rdata", rspRdata, e.rdata);
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;

    $display("[TB] reset mid-response sequence");
    @(negedge clk);
    driveReq(12'h004, 1'b1, 32'h55AA55AA, 4'hF);
    waitAccept(ok);
    reqValid = 1'b0;
    @(negedge clk);
    checkOutput("rst pre rsp_valid", 32'(rspValid), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rst rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst req_ready", 32'(reqReady), 32'd1);
    checkOutput("rst rsp_error", 32'(rspError), 32'd0);
    @(negedge clk);
    rspReady = 1'b1;
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post-rst no pulse", 32'(fieldWe | fieldRe), 32'd0);
      checkOutput("post-rst no response", 32'(rspValid), 32'd0);
    end
    rspReady = 1'b0;

    applyStimulus(vecs[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
